booth_r4_controller: RTL

//   Control FSM for the radix-4 Booth multiplier. Drives the iteration counter (ld_count/decr)
//   and consumes its count. Decodes the current Booth triplet {Q[1],Q[0],Q[-1]} from the

---
 rtl/booth_pkg.sv | 40 ++++
 rtl/booth_r4_controller_if.sv | 30 +++
 rtl/booth_r4_controller_decode.sv | 26 ++
 rtl/booth_r4_controller.sv | 74 +++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier controller slice.
// State/op encodings and operand-width derived sizes.
package booth_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EVAL  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_PM  = 3'd1,
      OP_P2M = 3'd2,
      OP_MM  = 3'd3,
      OP_M2M = 3'd4
   } op_t;

   function automatic int unsigned iter_of(input int unsigned n);
      return n / 2;
   endfunction

   function automatic int unsigned cw_of(input int unsigned n);
      return $clog2(n / 2) + 1;
   endfunction

   // Radix-4 recoding of the triplet {Q[1],Q[0],Q[-1]}
   function automatic op_t op_of(input logic [2:0] t);
      case (t)
         3'b001, 3'b010: return OP_PM;
         3'b011:         return OP_P2M;
         3'b100:         return OP_M2M;
         3'b101, 3'b110: return OP_MM;
         default:        return OP_NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_r4_controller_if.sv
// Host/datapath handshake bundle for the Booth controller.
// The controller side uses the slave modport; the host/datapath side uses master.
interface booth_r4_controller_if #(
   parameter int unsigned CW = 3
);
   logic          start;
   logic [CW-1:0] count;
   logic [2:0]    q_lsb;
   logic          ld_m;
   logic          ld_q;
   logic          clr_a;
   logic          ld_count;
   logic          ld_a;
   logic          sub;
   logic          sel_2m;
   logic          shift;
   logic          decr;
   logic          busy;
   logic          done;

   modport master (
      output start, count, q_lsb,
      input  ld_m, ld_q, clr_a, ld_count, ld_a, sub, sel_2m, shift, decr, busy, done
   );

   modport slave (
      input  start, count, q_lsb,
      output ld_m, ld_q, clr_a, ld_count, ld_a, sub, sel_2m, shift, decr, busy, done
   );
endinterface

// File: rtl/booth_r4_controller_decode.sv
// Combinational Booth triplet decode: q_lsb -> {ld_a, sub, sel_2m}.
// sub/sel_2m are forced low when no accumulate is requested.
module booth_r4_decode
   import booth_pkg::*;
(
   input  logic [2:0] q_lsb,
   output logic       ld_a,
   output logic       sub,
   output logic       sel_2m
);
   op_t op;

   always_comb begin
      op     = op_of(q_lsb);
      ld_a   = 1'b0;
      sub    = 1'b0;
      sel_2m = 1'b0;
      case (op)
         OP_PM:  ld_a = 1'b1;
         OP_P2M: begin ld_a = 1'b1; sel_2m = 1'b1; end
         OP_MM:  begin ld_a = 1'b1; sub = 1'b1; end
         OP_M2M: begin ld_a = 1'b1; sub = 1'b1; sel_2m = 1'b1; end
         default: ;
      endcase
   end
endmodule

// File: rtl/booth_r4_controller.sv
// Radix-4 Booth multiplier control FSM: sequences LOAD, then EVAL/SHIFT per
// iteration, then a one-cycle DONE; start/busy/done handshake to the host.
module booth_r4_controller
   import booth_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = cw_of(N)
) (
   input logic                  clk,
   input logic                  rst_n,
   booth_r4_controller_if.slave bus
);
   state_t state;
   state_t nxt;
   logic   load_r;
   logic   eval_r;
   logic   shift_r;
   logic   busy_r;
   logic   done_r;
   logic   dec_ld_a;
   logic   dec_sub;
   logic   dec_sel_2m;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.start) nxt = LOAD;
         LOAD:    nxt = EVAL;
         EVAL:    nxt = SHIFT;
         // count==0 means the counter was never loaded; finish rather than wrap
         SHIFT:   nxt = (bus.count <= CW'(1)) ? DONE : EVAL;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Moore outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         load_r  <= 1'b0;
         eval_r  <= 1'b0;
         shift_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state   <= nxt;
         load_r  <= (nxt == LOAD);
         eval_r  <= (nxt == EVAL);
         shift_r <= (nxt == SHIFT);
         busy_r  <= (nxt == LOAD) || (nxt == EVAL) || (nxt == SHIFT);
         done_r  <= (nxt == DONE);
      end
   end

   booth_r4_decode u_dec (
      .q_lsb  (bus.q_lsb),
      .ld_a   (dec_ld_a),
      .sub    (dec_sub),
      .sel_2m (dec_sel_2m)
   );

   assign bus.ld_m     = load_r;
   assign bus.ld_q     = load_r;
   assign bus.clr_a    = load_r;
   assign bus.ld_count = load_r;
   assign bus.ld_a     = eval_r & dec_ld_a;
   assign bus.sub      = eval_r & dec_sub;
   assign bus.sel_2m   = eval_r & dec_sel_2m;
   assign bus.shift    = shift_r;
   assign bus.decr     = shift_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
endmodule
